// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: canonical NOP, base opcodes, fetch FSM encoding and PC helper.
// FETCH_MISALIGN_CHECK_EN adds the FAULT state to the encoding.
package fetch_pkg;

  localparam logic [31:0] NOP_ENC = 32'h0000_0013;  // ADDI x0,x0,0

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
`ifdef FETCH_MISALIGN_CHECK_EN
    ST_FAULT = 2'd3,
`endif
    ST_DROP  = 2'd2
  } fetch_state_t;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry instruction+PC skid buffer with full flag; flush wins over load and unload.
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        full
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        full <= 1'b0;
    else if (flush)  full <= 1'b0;
    else if (load)   full <= 1'b1;
    else if (unload) full <= 1'b0;
  end

  // NOTE: payload registers carry no reset; full qualifies them, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (load && !flush) begin
      instr <= in_instr;
      pc    <= in_pc;
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC, imem req/ack handshake, output register with skid, redirects.
// FETCH_MISALIGN_CHECK_EN enables misaligned-redirect detection with a sticky FAULT state.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fetch_fault
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  tgt, tgt_nxt;
  logic         run;
  logic [31:0]  out_instr, out_instr_nxt;
  logic [31:0]  out_pc, out_pc_nxt;
  logic         out_valid, out_valid_nxt;
  logic         skid_load, skid_unload, skid_flush, skid_full;
  logic [31:0]  skid_instr, skid_pc;
  logic [31:0]  target_aln;
  logic         acked, consumed, locked;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault, fault_nxt;
  logic misalign;
  assign target_aln  = pc_target;
  assign misalign    = pc_target[1:0] != 2'b00;
  assign locked      = fault;
  assign fetch_fault = fault;
`else
  assign target_aln  = pc_target & 32'hFFFF_FFFC;
  assign locked      = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // run is cleared asynchronously, so req drops the instant reset asserts.
  assign imem_req    = run && !skid_full && (state == ST_FETCH || state == ST_DROP);
  assign imem_addr   = pc;
  assign acked       = imem_req && imem_ack;
  assign consumed    = !out_valid || !stall;
  assign instr_out   = out_valid ? out_instr : NOP_INSTR;
  assign instr_pc    = out_pc;
  assign instr_valid = out_valid;

  fetch_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .unload   (skid_unload),
    .flush    (skid_flush),
    .in_instr (imem_rdata),
    .in_pc    (pc),
    .instr    (skid_instr),
    .pc       (skid_pc),
    .full     (skid_full)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    tgt_nxt       = tgt;
    out_instr_nxt = out_instr;
    out_pc_nxt    = out_pc;
    out_valid_nxt = out_valid;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_flush    = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_nxt     = fault;
`endif

    if (pc_src && !locked) begin
      out_valid_nxt = 1'b0;
      skid_flush    = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (misalign) begin
        // An in-flight request must still be absorbed before fetch stops.
        fault_nxt = 1'b1;
        state_nxt = (imem_req && !acked) ? ST_DROP : ST_FAULT;
      end else
`endif
      if (imem_req && !acked) begin
        tgt_nxt   = target_aln;
        state_nxt = ST_DROP;
      end else begin
        pc_nxt    = target_aln;
        state_nxt = ST_FETCH;
      end
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (acked && consumed) begin
            out_instr_nxt = imem_rdata;
            out_pc_nxt    = pc;
            out_valid_nxt = 1'b1;
            pc_nxt        = pc_inc(pc);
          end else if (acked) begin
            skid_load = 1'b1;
            state_nxt = ST_HOLD;
          end else if (consumed) begin
            out_valid_nxt = 1'b0;
          end
        end
        ST_HOLD: begin
          if (consumed) begin
            out_instr_nxt = skid_instr;
            out_pc_nxt    = skid_pc;
            out_valid_nxt = 1'b1;
            skid_unload   = 1'b1;
            pc_nxt        = pc_inc(pc);
            state_nxt     = ST_FETCH;
          end
        end
        ST_DROP: begin
          if (consumed) out_valid_nxt = 1'b0;
          if (acked) begin
            pc_nxt = tgt;
`ifdef FETCH_MISALIGN_CHECK_EN
            state_nxt = fault ? ST_FAULT : ST_FETCH;
`else
            state_nxt = ST_FETCH;
`endif
          end
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        ST_FAULT: begin
          if (consumed) out_valid_nxt = 1'b0;
        end
`endif
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      tgt       <= RESET_PC;
      run       <= 1'b0;
      out_instr <= NOP_INSTR;
      out_pc    <= 32'h0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      tgt       <= tgt_nxt;
      run       <= 1'b1;
      out_instr <= out_instr_nxt;
      out_pc    <= out_pc_nxt;
      out_valid <= out_valid_nxt;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault <= 1'b0;
    else      fault <= fault_nxt;
  end
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for fetch; memory returns {16'hA5A5, addr[15:0]} for every address.
// Build with or without FETCH_MISALIGN_CHECK_EN; the fault step adapts.
module tb_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fetch_fault;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign imem_rdata = {16'hA5A5, imem_addr[15:0]};

  fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; imem_ack = 1'b0; stall = 1'b0; pc_src = 1'b0; pc_target = 32'h0;

    // 1. reset state, then streaming fetch with ack every cycle
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_instr", instr_out, NOP);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    tick();
    check("rst_req_clk", 32'(imem_req), 32'd0);
    rst = 1'b1; imem_ack = 1'b1;
    tick();
    check("s1_req", 32'(imem_req), 32'd1);
    check("s1_addr0", imem_addr, 32'h0);
    check("s1_valid0", 32'(instr_valid), 32'd0);
    tick();
    check("s1_addr4", imem_addr, 32'h4);
    check("s1_valid1", 32'(instr_valid), 32'd1);
    check("s1_instr0", instr_out, 32'hA5A5_0000);
    check("s1_ipc0", instr_pc, 32'h0);
    tick();
    check("s1_addr8", imem_addr, 32'h8);
    check("s1_instr4", instr_out, 32'hA5A5_0004);
    check("s1_ipc4", instr_pc, 32'h4);

    // 2. stall held for 3 cycles: word@8 parks in the skid, req drops
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s2_hold_req", 32'(imem_req), 32'd0);
      check("s2_hold_instr", instr_out, 32'hA5A5_0004);
      check("s2_hold_ipc", instr_pc, 32'h4);
    end
    stall = 1'b0;
    tick();
    check("s2_skid_instr", instr_out, 32'hA5A5_0008);
    check("s2_skid_ipc", instr_pc, 32'h8);
    check("s2_req_back", 32'(imem_req), 32'd1);
    check("s2_addr12", imem_addr, 32'hC);
    tick();
    check("s2_next_instr", instr_out, 32'hA5A5_000C);
    check("s2_next_ipc", instr_pc, 32'hC);
    check("s2_addr16", imem_addr, 32'h10);

    // 3. redirect while the request to 0x10 is unacked
    imem_ack = 1'b0;
    tick();
    check("s3_bubble_valid", 32'(instr_valid), 32'd0);
    check("s3_bubble_nop", instr_out, NOP);
    pc_src = 1'b1; pc_target = 32'h100;
    tick();
    pc_src = 1'b0;
    check("s3_drop_addr", imem_addr, 32'h10);
    check("s3_drop_req", 32'(imem_req), 32'd1);
    tick();
    check("s3_drop_addr_held", imem_addr, 32'h10);
    imem_ack = 1'b1;
    tick();
    check("s3_tgt_addr", imem_addr, 32'h100);
    check("s3_tgt_valid", 32'(instr_valid), 32'd0);
    check("s3_tgt_nop", instr_out, NOP);
    stall = 1'b1;  // no effect while instr_valid=0
    tick();
    check("s3_tgt_instr", instr_out, 32'hA5A5_0100);
    check("s3_tgt_ipc", instr_pc, 32'h100);
    check("s3_tgt_next", imem_addr, 32'h104);
    stall = 1'b0;

    // 4. redirect coincident with ack: rdata discarded
    pc_src = 1'b1; pc_target = 32'h200;
    tick();
    pc_src = 1'b0;
    check("s4_flush_valid", 32'(instr_valid), 32'd0);
    check("s4_flush_nop", instr_out, NOP);
    check("s4_addr", imem_addr, 32'h200);
    tick();
    check("s4_instr", instr_out, 32'hA5A5_0200);
    check("s4_ipc", instr_pc, 32'h200);

    // PC wrap at the top of the address space
    pc_src = 1'b1; pc_target = 32'hFFFF_FFFC;
    tick();
    pc_src = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_instr", instr_out, 32'hA5A5_FFFC);
    check("wrap_addr0", imem_addr, 32'h0);

    // 5. misaligned redirect coincident with ack
    pc_src = 1'b1; pc_target = 32'h102;
    tick();
    pc_src = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("s5_fault", 32'(fetch_fault), 32'd1);
    check("s5_req", 32'(imem_req), 32'd0);
    check("s5_valid", 32'(instr_valid), 32'd0);
    tick();
    tick();
    check("s5_fault_sticky", 32'(fetch_fault), 32'd1);
    check("s5_req_sticky", 32'(imem_req), 32'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("s5_fault_clr", 32'(fetch_fault), 32'd0);
    check("s5_restart", imem_addr, 32'h0);
`else
    check("s5_fault0", 32'(fetch_fault), 32'd0);
    check("s5_aligned", imem_addr, 32'h100);
    check("s5_req", 32'(imem_req), 32'd1);
    tick();
    check("s5_instr", instr_out, 32'hA5A5_0100);
`endif

    // 6. reset asserted mid-cycle with a request outstanding and ack pending
    imem_ack = 1'b0;
    tick();
    check("s6_pending_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("s6_req_drop", 32'(imem_req), 32'd0);
    check("s6_valid", 32'(instr_valid), 32'd0);
    check("s6_nop", instr_out, NOP);
    tick();
    check("s6_req_in_rst", 32'(imem_req), 32'd0);
    rst = 1'b1;
    tick();
    check("s6_restart_addr", imem_addr, 32'h0);
    check("s6_restart_req", 32'(imem_req), 32'd1);
    tick();
    check("s6_instr", instr_out, 32'hA5A5_0000);
    check("s6_ipc", instr_pc, 32'h0);
    check("s6_addr4", imem_addr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
